counter_sequencer_74161: RTL and testbench

//  Sequencer for one bidirectional_counter_74161 instance used as a programmable interval timer.
//  It drives the counter's DIC/LOAD/ENP/ENT and its clear input, and watches RCO.
//  It loads a preset, counts from PRESET up to 15 and reloads for the requested number of periods.
//  It reports BUSY/TICK/DONE to the parent design.

---
 rtl/counter_sequencer_74161.sv | 182 ++++++++++++++++++
 tb/tb_counter_sequencer_74161.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer_74161.sv
// -----------------------------------------------------------------------------
// counter_sequencer_74161
//
// Purpose
//   Sequences one bidirectional_counter_74161 instance to act as a
//   programmable interval timer. The sequencer loads a 4-bit preset into the
//   counter, lets it count up to 15, and then reloads it seamlessly for the
//   requested number of periods. Each period lasts 16-PRESET cycles. The
//   sequencer reports BUSY/TICK/DONE status to its parent.
//
// Ports
//   CLK         in   clock, shared with the counter instance
//   CLRBAR      in   asynchronous active-low reset
//   START       in   start request, only honoured in IDLE
//   STOP        in   abort request, honoured in any non-IDLE state
//   PAUSE       in   freeze the counter while high (COUNT only)
//   PRESET      in   [3:0] counter start value, latched on an accepted START
//   REPEAT      in   [REPEAT_W-1:0] number of periods (0 = until STOP)
//   RCO         in   counter ripple carry (QC == 15)
//   DIC         out  [3:0] counter parallel load data
//   LOAD        out  counter LOAD (0 = load, 1 = count/hold)
//   ENP         out  counter ENP
//   ENT         out  counter ENT
//   CNT_CLRBAR  out  counter clear, active-low, registered
//   BUSY        out  high whenever the sequencer is not IDLE
//   TICK        out  one-cycle pulse after each terminal-count cycle
//   DONE        out  high for the single DONE-state cycle
// -----------------------------------------------------------------------------
module counter_sequencer_74161 #(
  parameter int REPEAT_W = 8
) (
  input  logic                CLK,
  input  logic                CLRBAR,
  input  logic                START,
  input  logic                STOP,
  input  logic                PAUSE,
  input  logic [3:0]          PRESET,
  input  logic [REPEAT_W-1:0] REPEAT,
  input  logic                RCO,
  output logic [3:0]          DIC,
  output logic                LOAD,
  output logic                ENP,
  output logic                ENT,
  output logic                CNT_CLRBAR,
  output logic                BUSY,
  output logic                TICK,
  output logic                DONE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LDP   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [REPEAT_W-1:0] REM_ONE = REPEAT_W'(1);

  state_e              state_q, state_d;
  logic [3:0]          preset_q, preset_d;
  logic [REPEAT_W-1:0] rem_q, rem_d;
  logic                cnt_clrbar_q, cnt_clrbar_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                stop_hit;

  // STOP only has an effect once a run is in progress.
  assign stop_hit = STOP && (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and counter-control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    preset_d     = preset_q;
    rem_d        = rem_q;
    cnt_clrbar_d = 1'b1;
    tick_d       = 1'b0;
    LOAD         = 1'b1;
    ENP          = 1'b0;
    ENT          = 1'b0;
    DIC          = 4'd0;

    if (stop_hit) begin
      // Abort: hold the counter this cycle, clear it on the next one.
      // STOP takes priority over PAUSE and terminal handling.
      DIC          = preset_q;
      ENT          = (state_q == S_COUNT);
      state_d      = S_IDLE;
      rem_d        = '0;
      cnt_clrbar_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (START && !STOP) begin
            preset_d = PRESET;
            rem_d    = REPEAT;
            state_d  = S_LDP;
          end
        end

        S_LDP: begin
          // Parallel load of the preset; counting starts next cycle.
          DIC     = preset_q;
          LOAD    = 1'b0;
          ENP     = 1'b1;
          state_d = S_COUNT;
        end

        S_COUNT: begin
          DIC = preset_q;
          ENT = 1'b1;
          if (PAUSE) begin
            // Hold with ENT still high; a pending terminal is not consumed
            // and will be processed on the first unpaused cycle.
            ENP = 1'b0;
          end else if (RCO) begin
            tick_d = 1'b1;
            if (rem_q == REM_ONE) begin
              // Last period: park the counter at 15 and finish.
              ENP     = 1'b0;
              state_d = S_DONE;
            end else begin
              // Seamless reload: the counter takes the preset on this edge
              // instead of wrapping to 0.
              LOAD = 1'b0;
              ENP  = 1'b1;
              // rem == 0 means free-running; never decrement below 1.
              if (rem_q > REM_ONE) begin
                rem_d = rem_q - REM_ONE;
              end
            end
          end else begin
            ENP = 1'b1;
          end
        end

        S_DONE: begin
          DIC     = preset_q;
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge CLRBAR) begin
    if (!CLRBAR) begin
      state_q      <= S_IDLE;
      preset_q     <= 4'd0;
      rem_q        <= '0;
      cnt_clrbar_q <= 1'b0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      preset_q     <= preset_d;
      rem_q        <= rem_d;
      cnt_clrbar_q <= cnt_clrbar_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign CNT_CLRBAR = cnt_clrbar_q;
  assign TICK       = tick_q;
  assign DONE       = done_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_counter_sequencer_74161.sv
module tb_counter_sequencer_74161;

  localparam int REPEAT_W = 8;

  logic                CLK = 1'b0;
  logic                CLRBAR;
  logic                START;
  logic                STOP;
  logic                PAUSE;
  logic [3:0]          PRESET;
  logic [REPEAT_W-1:0] REPEAT;
  logic                RCO;
  logic [3:0]          DIC;
  logic                LOAD;
  logic                ENP;
  logic                ENT;
  logic                CNT_CLRBAR;
  logic                BUSY;
  logic                TICK;
  logic                DONE;

  // Behavioural 74161-style counter driven by the sequencer.
  logic [3:0] qc;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  counter_sequencer_74161 #(.REPEAT_W(REPEAT_W)) dut (
    .CLK        (CLK),
    .CLRBAR     (CLRBAR),
    .START      (START),
    .STOP       (STOP),
    .PAUSE      (PAUSE),
    .PRESET     (PRESET),
    .REPEAT     (REPEAT),
    .RCO        (RCO),
    .DIC        (DIC),
    .LOAD       (LOAD),
    .ENP        (ENP),
    .ENT        (ENT),
    .CNT_CLRBAR (CNT_CLRBAR),
    .BUSY       (BUSY),
    .TICK       (TICK),
    .DONE       (DONE)
  );

  always @(posedge CLK or negedge CNT_CLRBAR) begin
    if (!CNT_CLRBAR)       qc <= 4'd0;
    else if (!LOAD)        qc <= DIC;
    else if (ENP && ENT)   qc <= qc + 4'd1;
  end

  assign RCO = (qc == 4'd15);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nstep();
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q3 [7];
    int t3 [7];
    int d3 [7];
    int ticks;
    q3 = '{14, 15, 14, 15, 14, 15, 15};
    t3 = '{0, 0, 1, 0, 1, 0, 1};
    d3 = '{0, 0, 0, 0, 0, 0, 1};

    // ---- 1: reset ----
    CLRBAR = 1'b0; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0;
    PRESET = 4'd0; REPEAT = '0;
    nstep(); nstep();
    chk("rst_cnt_clrbar", 32'(CNT_CLRBAR), 32'd0);
    chk("rst_qc",         32'(qc),         32'd0);
    chk("rst_busy",       32'(BUSY),       32'd0);
    chk("rst_tick",       32'(TICK),       32'd0);
    chk("rst_done",       32'(DONE),       32'd0);
    chk("rst_load",       32'(LOAD),       32'd1);
    chk("rst_enp",        32'(ENP),        32'd0);
    chk("rst_ent",        32'(ENT),        32'd0);
    chk("rst_dic",        32'(DIC),        32'd0);
    CLRBAR = 1'b1;
    nstep();
    chk("rel_cnt_clrbar", 32'(CNT_CLRBAR), 32'd1);
    chk("rel_busy",       32'(BUSY),       32'd0);

    // ---- 2: PRESET=12, REPEAT=1 ----
    PRESET = 4'd12; REPEAT = 8'd1; START = 1'b1;
    nstep();
    START = 1'b0;
    #1;
    chk("t2_ldp_busy", 32'(BUSY), 32'd1);
    chk("t2_ldp_load", 32'(LOAD), 32'd0);
    chk("t2_ldp_enp",  32'(ENP),  32'd1);
    chk("t2_ldp_dic",  32'(DIC),  32'd12);
    for (int k = 0; k < 4; k++) begin
      nstep();
      chk("t2_qc",   32'(qc),   32'(12 + k));
      chk("t2_tick", 32'(TICK), 32'd0);
    end
    chk("t2_term_load", 32'(LOAD), 32'd1);
    chk("t2_term_enp",  32'(ENP),  32'd0);
    nstep();
    chk("t2_done",      32'(DONE), 32'd1);
    chk("t2_done_tick", 32'(TICK), 32'd1);
    chk("t2_done_busy", 32'(BUSY), 32'd1);
    chk("t2_done_qc",   32'(qc),   32'd15);
    nstep();
    chk("t2_idle_busy", 32'(BUSY), 32'd0);
    chk("t2_idle_done", 32'(DONE), 32'd0);
    chk("t2_idle_tick", 32'(TICK), 32'd0);
    chk("t2_idle_qc",   32'(qc),   32'd15);

    // ---- 3: PRESET=14, REPEAT=3 ----
    PRESET = 4'd14; REPEAT = 8'd3; START = 1'b1;
    nstep();
    START = 1'b0;
    ticks = 0;
    for (int k = 0; k < 7; k++) begin
      nstep();
      chk("t3_qc",   32'(qc),   32'(q3[k]));
      chk("t3_tick", 32'(TICK), 32'(t3[k]));
      chk("t3_done", 32'(DONE), 32'(d3[k]));
      if (TICK) ticks++;
    end
    chk("t3_tick_count", 32'(ticks), 32'd3);
    nstep();
    chk("t3_idle_busy", 32'(BUSY), 32'd0);

    // ---- 4: PRESET=15, REPEAT=0, then STOP ----
    PRESET = 4'd15; REPEAT = 8'd0; START = 1'b1;
    nstep();
    START = 1'b0;
    #1;
    chk("t4_ldp_dic", 32'(DIC), 32'd15);
    nstep();
    chk("t4_first_tick", 32'(TICK), 32'd0);
    for (int k = 0; k < 4; k++) begin
      nstep();
      chk("t4_tick", 32'(TICK), 32'd1);
      chk("t4_qc",   32'(qc),   32'd15);
    end
    STOP = 1'b1;
    #1;
    chk("t4_stop_load", 32'(LOAD), 32'd1);
    chk("t4_stop_enp",  32'(ENP),  32'd0);
    nstep();
    STOP = 1'b0;
    chk("t4_clr_low",  32'(CNT_CLRBAR), 32'd0);
    chk("t4_clr_qc",   32'(qc),         32'd0);
    chk("t4_clr_busy", 32'(BUSY),       32'd0);
    chk("t4_clr_tick", 32'(TICK),       32'd0);
    chk("t4_clr_done", 32'(DONE),       32'd0);
    nstep();
    chk("t4_clr_high", 32'(CNT_CLRBAR), 32'd1);
    chk("t4_after_qc", 32'(qc),         32'd0);

    // ---- 5: PRESET=10, REPEAT=0, PAUSE at terminal ----
    PRESET = 4'd10; REPEAT = 8'd0; START = 1'b1;
    nstep();
    START = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nstep();
      chk("t5_qc", 32'(qc), 32'(10 + k));
    end
    PAUSE = 1'b1;
    #1;
    chk("t5_pause_enp",  32'(ENP),  32'd0);
    chk("t5_pause_ent",  32'(ENT),  32'd1);
    chk("t5_pause_load", 32'(LOAD), 32'd1);
    for (int k = 0; k < 3; k++) begin
      nstep();
      chk("t5_pause_qc",   32'(qc),   32'd15);
      chk("t5_pause_tick", 32'(TICK), 32'd0);
    end
    PAUSE = 1'b0;
    nstep();
    chk("t5_reload_qc",   32'(qc),   32'd10);
    chk("t5_reload_tick", 32'(TICK), 32'd1);

    // ---- 6: START mid-run ignored, then async CLRBAR ----
    PRESET = 4'd3; REPEAT = 8'd1; START = 1'b1;
    nstep();
    START = 1'b0;
    chk("t6_qc",   32'(qc),   32'd11);
    chk("t6_dic",  32'(DIC),  32'd10);
    chk("t6_busy", 32'(BUSY), 32'd1);
    for (int k = 0; k < 4; k++) nstep();
    chk("t6_term_qc", 32'(qc), 32'd15);
    nstep();
    chk("t6_reload_qc",   32'(qc),   32'd10);
    chk("t6_reload_tick", 32'(TICK), 32'd1);
    CLRBAR = 1'b0;
    #1;
    chk("t6_arst_busy", 32'(BUSY),       32'd0);
    chk("t6_arst_tick", 32'(TICK),       32'd0);
    chk("t6_arst_done", 32'(DONE),       32'd0);
    chk("t6_arst_clr",  32'(CNT_CLRBAR), 32'd0);
    chk("t6_arst_qc",   32'(qc),         32'd0);
    chk("t6_arst_load", 32'(LOAD),       32'd1);
    chk("t6_arst_enp",  32'(ENP),        32'd0);
    chk("t6_arst_dic",  32'(DIC),        32'd0);
    nstep();
    CLRBAR = 1'b1;
    nstep();

    // ---- START together with STOP in IDLE is not accepted ----
    START = 1'b1; STOP = 1'b1;
    nstep();
    START = 1'b0; STOP = 1'b0;
    chk("idle_ss_busy", 32'(BUSY),       32'd0);
    chk("idle_ss_clr",  32'(CNT_CLRBAR), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
